timer_apb_slave: RTL and testbench
==================================

Name: timer_apb_slave

Overview:
- APB completer and register file for the 8-bit timer.
- Sits between the APB bus, driven by the CPU bus functional model in the test bench, and the timer counter core.
- Decodes APB transfers, inserts a configurable number of wait states, and drives pready/pslverr.
- Holds TDR, TCR and TSR, exposes their fields to the counter, and returns TCNT on read.

Parameters:
- WAIT_CYCLES, 0, number of pready-low cycles inserted in every ACCESS phase (0..15).
- ADDR_W, 8, paddr width.
- DATA_W, 8, pwdata/prdata width.

Ports:
- pclk  input  1  APB clock; all state changes on its rising edge.
- presetn  input  1  asynchronous active-low reset.
- psel  input  1  APB select.
- penable  input  1  APB enable (ACCESS phase).
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDR_W  register address.
- pwdata  input  DATA_W  write data.
- prdata  output  DATA_W  read data, valid while pready=1.
- pready  output  1  transfer completion.
- pslverr  output  1  error response, valid while pready=1.
- tdr_o  output  8  TDR value, used as the counter reload value.
- load_o  output  1  TCR[7], load request.
- dw_o  output  1  TCR[5], 1 = count down.
- en_o  output  1  TCR[4], count enable.
- cks_o  output  2  TCR[1:0], clock select: 00 = pclk/2, 01 = pclk/4, 10 = pclk/8, 11 = pclk/16.
- tcnt_i  input  8  current counter value.
- ovf_set_i  input  1  one-cycle overflow pulse from the counter.
- udf_set_i  input  1  one-cycle underflow pulse from the counter.

Behaviour:
- Reset (presetn=0, asynchronous):
  - TDR=0x00, TCR=0x00, TSR=0x00.
  - prdata=0x00, pready=0, pslverr=0, FSM=IDLE, wait counter=0.
  - Reset asserted mid-transfer aborts the transfer with no register update.
- Address map:
  - 0x00 TDR, read/write, all 8 bits.
  - 0x01 TCR, read/write. Implemented bits are 7, 5, 4, 1 and 0. Bits 6, 3 and 2 are ignored on write and read 0.
  - 0x02 TSR, read/write-0-to-clear. Bit1 = UDF, bit0 = OVF. Bits 7:2 read 0.
  - 0x03 TCNT, read-only; returns tcnt_i sampled in the completion cycle.
  - Any other address is invalid.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when psel=1 and penable=0.
  - SETUP -> ACCESS on the next edge (penable=1 required). On entry to ACCESS the wait counter is loaded with WAIT_CYCLES.
  - In ACCESS, pready=0 while counter>0 and the counter decrements each cycle. When counter=0, pready=1 for exactly one cycle.
  - After the completion cycle: back to SETUP if psel=1 and penable=0, otherwise IDLE.
  - psel deasserting mid-ACCESS returns to IDLE with no update and no pready.
- Timing:
  - With WAIT_CYCLES=0, a transfer takes 2 pclk cycles: pready is high in the first ACCESS cycle.
  - General case: WAIT_CYCLES+2 cycles.
- Commit and read timing:
  - Write data commits on the pclk edge that ends the pready=1 cycle; it is visible on outputs the following cycle.
  - prdata is driven in the pready=1 cycle and returns 0x00 otherwise.
- Errors:
  - pslverr=1 together with pready=1 for an invalid address or a write to 0x03.
  - An erroring write changes no register. An erroring read returns prdata=0x00.
- TSR behaviour:
  - Each bit is set by its set pulse and is sticky.
  - A write clears a bit where pwdata has 0; a 1 in pwdata leaves the bit unchanged.
  - A set pulse in the same cycle as a clearing write wins, so the bit stays 1.
  - Setting an already-set bit has no effect.
- TCR load bit:
  - load_o is level (TCR[7] as written); software clears it by writing TCR again.
  - The counter samples load_o; this block does not self-clear it.
- All register outputs are direct register copies with no combinational path from the APB inputs.

Test Plan:
- Reset then read 0x00..0x03 with tcnt_i=0x5A -> reads 0x00, 0x00, 0x00, 0x5A; pslverr=0; each read completes in 2 cycles (WAIT_CYCLES=0).
- Write 0x00=0xFF, then 0x01=0x82, then 0x01=0x32:
  - After the second write, tdr_o=0xFF, load_o=1, dw_o=0, en_o=0, cks_o=2.
  - After the third write, load_o=0, dw_o=1, en_o=1, cks_o=2.
  - Reading 0x01 returns 0x32.
  - Writing 0x01=0xFF reads back 0xB3.
- Pulse udf_set_i once -> TSR reads 0x02. Write 0x02=0x02 -> still 0x02. Write 0x02=0x00 -> 0x00.
- Pulse ovf_set_i in the exact completion cycle of a write 0x02=0x00 while TSR=0x01 -> TSR remains 0x01.
- Write 0x03=0x11 and read 0x07 -> pslverr=1 on both; no register changes; prdata=0x00.
- WAIT_CYCLES=3: write TDR=0xA5 -> pready low 3 ACCESS cycles then high 1 cycle (5 cycles total). Deasserting presetn during the wait -> TDR stays 0x00 and all outputs return to reset values immediately.

Source files
------------

// File: rtl/timer_apb_slave_if.sv
// APB bus bundle between the CPU-side requester and the timer register block.
// The requester drives the select/enable/address/data group; the timer answers with data and handshake.
interface timer_apb_slave_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/timer_apb_slave.sv
// APB completer and register file (TDR/TCR/TSR) for the 8-bit timer, with optional wait states.
//
// state    | meaning
// IDLE     | no transfer in flight; a setup phase on the bus starts one
// ACCESS   | access phase, wait counter running, pready low
// COMPLETE | pready high for one cycle; writes commit on the closing edge
module timer_apb_slave #(
   parameter int WAIT_CYCLES = 0,
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8
) (
   input  logic              pclk,
   input  logic              presetn,
   timer_apb_slave_if.slave  apb,
   output logic [7:0]        tdr_o,
   output logic              load_o,
   output logic              dw_o,
   output logic              en_o,
   output logic [1:0]        cks_o,
   input  logic [7:0]        tcnt_i,
   input  logic              ovf_set_i,
   input  logic              udf_set_i
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      COMPLETE = 2'd2
   } state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
   localparam logic [7:0] TCR_MASK  = 8'hB3;

   state_t     state;
   logic [3:0] wait_cnt;
   logic [1:0] addr_q;
   logic       write_q;
   logic       err_q;
   logic       pready_q;
   logic       pslverr_q;
   logic [7:0] tdr;
   logic [7:0] tcr;
   logic [1:0] tsr;
   logic [1:0] tsr_next;
   logic [7:0] rdata;
   logic       setup_err;
   logic       commit_wr;

   // Decoded in the setup phase; the address and direction are held stable by the bus until completion.
   assign setup_err = (apb.paddr >= ADDR_W'(4)) || (apb.pwrite && (apb.paddr == ADDR_W'(3)));
   assign commit_wr = (state == COMPLETE) && apb.psel && apb.penable && write_q && !err_q;

   // A set pulse is OR-ed in after the clear, so it wins against a same-cycle clearing write.
   always_comb begin
      tsr_next = tsr;
      if (commit_wr && (addr_q == 2'd2)) begin
         tsr_next = tsr & apb.pwdata[1:0];
      end
      tsr_next = tsr_next | {udf_set_i, ovf_set_i};
   end

   always_comb begin
      rdata = 8'h00;
      if (pready_q && !write_q && !err_q) begin
         case (addr_q)
            2'd0:    rdata = tdr;
            2'd1:    rdata = tcr;
            2'd2:    rdata = {6'b0, tsr};
            default: rdata = tcnt_i;
         endcase
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state     <= IDLE;
         wait_cnt  <= 4'd0;
         addr_q    <= 2'd0;
         write_q   <= 1'b0;
         err_q     <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         tdr       <= 8'h00;
         tcr       <= 8'h00;
         tsr       <= 2'b00;
      end else begin
         tsr <= tsr_next;
         case (state)
            IDLE: begin
               if (apb.psel && !apb.penable) begin
                  addr_q   <= apb.paddr[1:0];
                  write_q  <= apb.pwrite;
                  err_q    <= setup_err;
                  wait_cnt <= WAIT_INIT;
                  if (WAIT_INIT == 4'd0) begin
                     state     <= COMPLETE;
                     pready_q  <= 1'b1;
                     pslverr_q <= setup_err;
                  end else begin
                     state <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (!apb.psel) begin
                  state <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
                  if (wait_cnt == 4'd1) begin
                     state     <= COMPLETE;
                     pready_q  <= 1'b1;
                     pslverr_q <= err_q;
                  end
               end
            end
            COMPLETE: begin
               state     <= IDLE;
               pready_q  <= 1'b0;
               pslverr_q <= 1'b0;
               if (commit_wr) begin
                  case (addr_q)
                     2'd0:    tdr <= apb.pwdata[7:0];
                     2'd1:    tcr <= apb.pwdata[7:0] & TCR_MASK;
                     default: ;
                  endcase
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign apb.pready  = pready_q;
   assign apb.pslverr = pslverr_q;
   assign apb.prdata  = DATA_W'(rdata);

   assign tdr_o  = tdr;
   assign load_o = tcr[7];
   assign dw_o   = tcr[5];
   assign en_o   = tcr[4];
   assign cks_o  = tcr[1:0];

endmodule

// File: tb/tb_timer_apb_slave.sv
// Bench for timer_apb_slave: two instances (0 and 3 wait states), directed register scenarios
// plus randomized traffic, all compared every cycle against a transaction-level model.
module tb_timer_apb_slave;

   localparam int WAITS [2] = '{0, 3};

   logic pclk = 1'b0;
   always #5 pclk = ~pclk;

   logic [1:0] rst_r    = 2'b00;
   logic [1:0] psel_r   = 2'b00;
   logic [1:0] pen_r    = 2'b00;
   logic [1:0] pwr_r    = 2'b00;
   logic [7:0] paddr_r  [2] = '{8'h00, 8'h00};
   logic [7:0] pwdata_r [2] = '{8'h00, 8'h00};
   logic [7:0] tcnt     = 8'h5A;
   logic       ovf      = 1'b0;
   logic       udf      = 1'b0;
   bit         rand_en  = 1'b0;

   wire [1:0][7:0] tdr_w;
   wire [1:0][7:0] rd_w;
   wire [1:0][1:0] cks_w;
   wire [1:0]      load_w, dw_w, en_w, pready_w, pslverr_w;

   timer_apb_slave_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
   timer_apb_slave_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();

   assign bus0.psel    = psel_r[0];
   assign bus0.penable = pen_r[0];
   assign bus0.pwrite  = pwr_r[0];
   assign bus0.paddr   = paddr_r[0];
   assign bus0.pwdata  = pwdata_r[0];
   assign bus1.psel    = psel_r[1];
   assign bus1.penable = pen_r[1];
   assign bus1.pwrite  = pwr_r[1];
   assign bus1.paddr   = paddr_r[1];
   assign bus1.pwdata  = pwdata_r[1];
   assign rd_w[0]      = bus0.prdata;
   assign rd_w[1]      = bus1.prdata;
   assign pready_w[0]  = bus0.pready;
   assign pready_w[1]  = bus1.pready;
   assign pslverr_w[0] = bus0.pslverr;
   assign pslverr_w[1] = bus1.pslverr;

   timer_apb_slave #(.WAIT_CYCLES(0), .ADDR_W(8), .DATA_W(8)) dut0 (
      .pclk(pclk), .presetn(rst_r[0]), .apb(bus0),
      .tdr_o(tdr_w[0]), .load_o(load_w[0]), .dw_o(dw_w[0]), .en_o(en_w[0]), .cks_o(cks_w[0]),
      .tcnt_i(tcnt), .ovf_set_i(ovf), .udf_set_i(udf)
   );

   timer_apb_slave #(.WAIT_CYCLES(3), .ADDR_W(8), .DATA_W(8)) dut1 (
      .pclk(pclk), .presetn(rst_r[1]), .apb(bus1),
      .tdr_o(tdr_w[1]), .load_o(load_w[1]), .dw_o(dw_w[1]), .en_o(en_w[1]), .cks_o(cks_w[1]),
      .tcnt_i(tcnt), .ovf_set_i(ovf), .udf_set_i(udf)
   );

   int nchecks = 0;
   int nfail   = 0;

   function automatic void chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s dut%0d t=%0t got=%0h expected=%0h", name, d, $time, act, exp);
      end
   endfunction

   // Transaction-level model: register contents plus the cycle index at which each transfer completes.
   int         cyc = 0;
   logic [7:0] m_tdr  [2] = '{8'h00, 8'h00};
   logic [7:0] m_tcr  [2] = '{8'h00, 8'h00};
   logic [1:0] m_tsr  [2] = '{2'b00, 2'b00};
   bit         m_busy [2] = '{1'b0, 1'b0};
   int         m_start[2] = '{0, 0};
   bit         m_wr   [2] = '{1'b0, 1'b0};
   logic [7:0] m_addr [2] = '{8'h00, 8'h00};

   function automatic bit m_err(input int d);
      return (m_addr[d] > 8'd3) || (m_wr[d] && m_addr[d] == 8'd3);
   endfunction

   function automatic logic [7:0] m_read(input int d);
      case (m_addr[d])
         8'd0:    return m_tdr[d];
         8'd1:    return m_tcr[d];
         8'd2:    return {6'b0, m_tsr[d]};
         default: return tcnt;
      endcase
   endfunction

   always @(posedge pclk) begin
      logic [1:0] tsr_n;
      for (int d = 0; d < 2; d++) begin
         if (!rst_r[d]) begin
            m_tdr[d] = 8'h00; m_tcr[d] = 8'h00; m_tsr[d] = 2'b00; m_busy[d] = 1'b0;
         end else begin
            tsr_n = m_tsr[d];
            if (m_busy[d]) begin
               if (!psel_r[d]) begin
                  m_busy[d] = 1'b0;
               end else if (cyc == m_start[d] + WAITS[d] + 1) begin
                  if (m_wr[d] && !m_err(d)) begin
                     if (m_addr[d] == 8'd0) m_tdr[d] = pwdata_r[d];
                     if (m_addr[d] == 8'd1) m_tcr[d] = pwdata_r[d] & 8'hB3;
                     if (m_addr[d] == 8'd2) tsr_n = m_tsr[d] & pwdata_r[d][1:0];
                  end
                  m_busy[d] = 1'b0;
               end
            end else if (psel_r[d] && !pen_r[d]) begin
               m_busy[d]  = 1'b1;
               m_start[d] = cyc;
               m_wr[d]    = pwr_r[d];
               m_addr[d]  = paddr_r[d];
            end
            m_tsr[d] = tsr_n | {udf, ovf};
         end
      end
      cyc++;
   end

   always @(negedge pclk) begin
      bit done;
      for (int d = 0; d < 2; d++) begin
         if (rst_r[d]) begin
            done = m_busy[d] && (cyc == m_start[d] + WAITS[d] + 1);
            chk("pready", d, 32'(pready_w[d]), 32'(done));
            chk("pslverr", d, 32'(pslverr_w[d]), 32'(done && m_err(d)));
            chk("prdata", d, 32'(rd_w[d]), (done && !m_wr[d] && !m_err(d)) ? 32'(m_read(d)) : 32'h0);
            chk("tdr_o", d, 32'(tdr_w[d]), 32'(m_tdr[d]));
            chk("tcr_fields", d, {27'b0, load_w[d], dw_w[d], en_w[d], cks_w[d]},
                {27'b0, m_tcr[d][7], m_tcr[d][5], m_tcr[d][4], m_tcr[d][1:0]});
         end
      end
   end

   task automatic tick();
      if (rand_en) begin
         ovf  = ($urandom_range(0, 5) == 0);
         udf  = ($urandom_range(0, 5) == 0);
         tcnt = 8'($urandom);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge pclk); #1; tick();
      end
   endtask

   task automatic xfer(input int d, input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                       input bit ovf_done, output logic [7:0] rdata, output bit err, output int ncyc);
      int guard;
      @(posedge pclk); #1; tick();
      psel_r[d] = 1'b1; pen_r[d] = 1'b0; pwr_r[d] = wr; paddr_r[d] = addr; pwdata_r[d] = wdata;
      @(posedge pclk); #1; tick();
      pen_r[d] = 1'b1;
      if (ovf_done) ovf = 1'b1;
      ncyc  = 2;
      guard = 0;
      @(negedge pclk);
      while (pready_w[d] !== 1'b1 && guard < 40) begin
         @(posedge pclk); #1; tick();
         ncyc++; guard++;
         @(negedge pclk);
      end
      chk("no_timeout", d, 32'(guard < 40), 32'd1);
      rdata = rd_w[d];
      err   = pslverr_w[d];
      @(posedge pclk); #1;
      psel_r[d] = 1'b0; pen_r[d] = 1'b0;
      if (ovf_done) ovf = 1'b0;
      tick();
   endtask

   task automatic rd(input int d, input logic [7:0] addr, input logic [7:0] exp, input bit exp_err);
      logic [7:0] r; bit e; int n;
      xfer(d, 1'b0, addr, 8'h00, 1'b0, r, e, n);
      chk("read_data", d, 32'(r), 32'(exp));
      chk("read_err", d, 32'(e), 32'(exp_err));
   endtask

   task automatic wr(input int d, input logic [7:0] addr, input logic [7:0] data, input bit exp_err);
      logic [7:0] r; bit e; int n;
      xfer(d, 1'b1, addr, data, 1'b0, r, e, n);
      chk("write_err", d, 32'(e), 32'(exp_err));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] r; bit e; int n;
      idle(3);
      rst_r = 2'b11;
      idle(1);

      // reset values, 2-cycle reads
      for (int a = 0; a < 4; a++) begin
         xfer(0, 1'b0, 8'(a), 8'h00, 1'b0, r, e, n);
         chk("reset_read", 0, 32'(r), (a == 3) ? 32'h5A : 32'h00);
         chk("reset_read_err", 0, 32'(e), 32'd0);
         chk("read_cycles_w0", 0, 32'(n), 32'd2);
      end

      wr(0, 8'h00, 8'hFF, 1'b0);
      wr(0, 8'h01, 8'h82, 1'b0);
      chk("tdr_ff", 0, 32'(tdr_w[0]), 32'hFF);
      chk("tcr_82", 0, {27'b0, load_w[0], dw_w[0], en_w[0], cks_w[0]}, {27'b0, 5'b1_0_0_10});
      wr(0, 8'h01, 8'h32, 1'b0);
      chk("tcr_32", 0, {27'b0, load_w[0], dw_w[0], en_w[0], cks_w[0]}, {27'b0, 5'b0_1_1_10});
      rd(0, 8'h01, 8'h32, 1'b0);
      wr(0, 8'h01, 8'hFF, 1'b0);
      rd(0, 8'h01, 8'hB3, 1'b0);

      // TSR sticky and write-0-to-clear
      @(posedge pclk); #1; udf = 1'b1;
      @(posedge pclk); #1; udf = 1'b0;
      rd(0, 8'h02, 8'h02, 1'b0);
      wr(0, 8'h02, 8'h02, 1'b0);
      rd(0, 8'h02, 8'h02, 1'b0);
      wr(0, 8'h02, 8'h00, 1'b0);
      rd(0, 8'h02, 8'h00, 1'b0);
      @(posedge pclk); #1; ovf = 1'b1;
      @(posedge pclk); #1; ovf = 1'b0;
      rd(0, 8'h02, 8'h01, 1'b0);
      xfer(0, 1'b1, 8'h02, 8'h00, 1'b1, r, e, n);
      rd(0, 8'h02, 8'h01, 1'b0);

      // error responses leave registers alone
      wr(0, 8'h03, 8'h11, 1'b1);
      rd(0, 8'h07, 8'h00, 1'b1);
      chk("tdr_after_err", 0, 32'(tdr_w[0]), 32'hFF);
      rd(0, 8'h01, 8'hB3, 1'b0);

      // reset during the wait states of a TDR write
      @(posedge pclk); #1;
      psel_r[1] = 1'b1; pen_r[1] = 1'b0; pwr_r[1] = 1'b1; paddr_r[1] = 8'h00; pwdata_r[1] = 8'hA5;
      @(posedge pclk); #1; pen_r[1] = 1'b1;
      @(posedge pclk); #2; rst_r[1] = 1'b0;
      #1;
      chk("rst_pready", 1, 32'(pready_w[1]), 32'd0);
      chk("rst_pslverr", 1, 32'(pslverr_w[1]), 32'd0);
      chk("rst_prdata", 1, 32'(rd_w[1]), 32'd0);
      chk("rst_tdr", 1, 32'(tdr_w[1]), 32'd0);
      chk("rst_tcr", 1, {27'b0, load_w[1], dw_w[1], en_w[1], cks_w[1]}, 32'd0);
      psel_r[1] = 1'b0; pen_r[1] = 1'b0;
      idle(2);
      rst_r[1] = 1'b1;
      idle(2);
      chk("tdr_after_abort", 1, 32'(tdr_w[1]), 32'd0);

      // 3 wait states: 5-cycle transfers
      xfer(1, 1'b1, 8'h00, 8'hA5, 1'b0, r, e, n);
      chk("write_cycles_w3", 1, 32'(n), 32'd5);
      chk("tdr_a5", 1, 32'(tdr_w[1]), 32'hA5);
      xfer(1, 1'b0, 8'h00, 8'h00, 1'b0, r, e, n);
      chk("read_cycles_w3", 1, 32'(n), 32'd5);
      chk("read_a5", 1, 32'(r), 32'hA5);

      // randomized traffic on both instances, including psel drops during wait states
      rand_en = 1'b1;
      for (int i = 0; i < 200; i++) begin
         int d;
         logic [7:0] a;
         d = int'($urandom_range(0, 1));
         a = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
         if (d == 1 && $urandom_range(0, 7) == 0) begin
            @(posedge pclk); #1; tick();
            psel_r[1] = 1'b1; pen_r[1] = 1'b0; pwr_r[1] = 1'($urandom); paddr_r[1] = a; pwdata_r[1] = 8'($urandom);
            @(posedge pclk); #1; tick(); pen_r[1] = 1'b1;
            idle($urandom_range(0, 2));
            psel_r[1] = 1'b0; pen_r[1] = 1'b0;
         end else begin
            xfer(d, 1'($urandom), a, 8'($urandom), 1'b0, r, e, n);
         end
         idle($urandom_range(0, 2));
      end
      rand_en = 1'b0;
      ovf = 1'b0; udf = 1'b0;
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
      $finish;
   end

endmodule
